// File: rtl/tt_um_spike_encoder.sv
// Rate-to-spike encoder: a 256-step window turns an 8-bit intensity into a
// spike train, either by accumulator carry (deterministic) or LFSR compare (stochastic).
module tt_um_spike_encoder #(
  parameter int         REFRAC    = 0,
  parameter logic [7:0] LFSR_SEED = 8'hB8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] REFRAC_LOAD = 4'(REFRAC);
  localparam logic [5:0] COUNT_MAX   = 6'd63;

  logic [1:0] state;
  logic [7:0] rate;
  logic [7:0] acc;
  logic [7:0] window;
  logic [3:0] refrac;
  logic [5:0] count;
  logic [7:0] lfsr;
  logic       spike;
  logic       done;

  logic       load;
  logic       pause;
  logic       mode;
  logic [8:0] sum;
  logic [7:0] lfsr_next;
  logic       raw_spike;
  logic       fire;
  logic       unused_uio;

  assign load  = uio_in[0];
  assign pause = uio_in[1];
  assign mode  = uio_in[2];
  assign unused_uio = &{1'b0, uio_in[7:3]};

  assign sum       = {1'b0, acc} + {1'b0, rate};
  // Fibonacci taps 8,6,5,4 -> state bits 7,5,4,3, fed back into bit 0
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign raw_spike = mode ? (lfsr < rate) : sum[8];
  assign fire      = raw_spike && (refrac == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rate   <= 8'd0;
      acc    <= 8'd0;
      window <= 8'd0;
      refrac <= 4'd0;
      count  <= 6'd0;
      lfsr   <= LFSR_SEED;
      spike  <= 1'b0;
      done   <= 1'b0;
    end else if (ena) begin
      if (load) begin
        state  <= RUN;
        rate   <= ui_in;
        acc    <= 8'd0;
        window <= 8'd0;
        refrac <= 4'd0;
        count  <= 6'd0;
        lfsr   <= LFSR_SEED;
        spike  <= 1'b0;
        done   <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            if (pause) begin
              spike <= 1'b0;
            end else begin
              window <= window + 8'd1;
              lfsr   <= lfsr_next;
              if (!mode) acc <= sum[7:0];
              spike <= fire;
              // A carry blocked by the refractory period is simply lost
              if (fire) begin
                refrac <= REFRAC_LOAD;
                if (count != COUNT_MAX) count <= count + 6'd1;
              end else if (refrac != 4'd0) begin
                refrac <= refrac - 4'd1;
              end
              if (window == 8'hFF) begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
          DONE: begin
            spike <= 1'b0;
          end
          IDLE: begin
            spike <= 1'b0;
            done  <= 1'b0;
            count <= 6'd0;
          end
          default: begin
            state <= IDLE;
            spike <= 1'b0;
            done  <= 1'b0;
            count <= 6'd0;
          end
        endcase
      end
    end
  end

  assign uo_out  = {count, done, spike & ena};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule
